// File: rtl/receptor_serial_activo.sv
// Serial-to-parallel receiver: bit-granular COMMA hunt, byte lock after COMMA_COUNT aligned commas,
// then packs data bytes MSB-first into 32-bit words. Outputs registered; no backpressure (consumer samples the valid_out level).
module receptor_serial_activo #(
   parameter logic [7:0] COMMA       = 8'hBC,
   parameter int         COMMA_COUNT = 4
) (
   input  logic        clk_32f,
   input  logic        reset,
   input  logic        data_in,
   output logic [31:0] data_out,
   output logic        valid_out,
   output logic        active
);

   localparam logic [1:0] SEARCH = 2'd0;
   localparam logic [1:0] ALIGN  = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;

   localparam logic [3:0] BC_LAST = 4'(COMMA_COUNT - 1);
   localparam logic [3:0] BC_FULL = 4'(COMMA_COUNT);

   logic [1:0]  state;
   logic [7:0]  sr;
   logic [2:0]  bit_cnt;
   logic [3:0]  bc_cnt;
   logic [1:0]  byte_idx;
   logic [23:0] held;
   logic [7:0]  nb;
   logic        boundary;
   logic        is_comma;

   always_comb begin
      nb       = {sr[6:0], data_in};
      boundary = (bit_cnt == 3'd7);
      is_comma = (nb == COMMA);
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state     <= SEARCH;
         sr        <= 8'h00;
         bit_cnt   <= 3'd0;
         bc_cnt    <= 4'd0;
         byte_idx  <= 2'd0;
         held      <= 24'h0;
         data_out  <= 32'h0;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         sr      <= nb;
         bit_cnt <= bit_cnt + 3'd1;
         case (state)
            SEARCH: begin
               // A match here defines the byte grid: the next boundary is 8 edges later.
               if (is_comma) begin
                  bit_cnt <= 3'd0;
                  bc_cnt  <= 4'd1;
                  state   <= ALIGN;
               end
            end
            ALIGN: begin
               if (boundary) begin
                  if (is_comma) begin
                     if (bc_cnt == BC_LAST) begin
                        bc_cnt <= BC_FULL;
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end else begin
                        bc_cnt <= bc_cnt + 4'd1;
                     end
                  end else begin
                     bc_cnt <= 4'd0;
                     state  <= SEARCH;
                  end
               end
            end
            ACTIVE: begin
               if (boundary) begin
                  if (is_comma) begin
                     // Idle symbol: abandon any partial word, keep the last full word visible.
                     byte_idx  <= 2'd0;
                     valid_out <= 1'b0;
                  end else if (byte_idx == 2'd3) begin
                     data_out  <= {held, nb};
                     valid_out <= 1'b1;
                     byte_idx  <= 2'd0;
                  end else begin
                     case (byte_idx)
                        2'd0:    held[23:16] <= nb;
                        2'd1:    held[15:8]  <= nb;
                        default: held[7:0]   <= nb;
                     endcase
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

endmodule
